// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// owner codes and default widths/latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam int MEM_LAT_DEF = 4;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;

  // Latency counter must hold values 0..lat.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// slave  = arbiter view, master = view of the caches/memory/bench around it.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // I-cache fill path
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  // D-cache fill / writeback path
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  // Main memory port
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  // Status
  logic              busy;
  logic [1:0]        owner;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_stall,
    output i_done, i_rdata, d_done, d_rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
           busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_stall,
    input  i_done, i_rdata, d_done, d_rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
           busy, owner
  );
endinterface

// File: rtl/mem_arbiter_arb_pick2.sv
// Two-requester winner picker (combinational).
// Build option ARB_RR_EN: round-robin using last_owner; otherwise fixed D-over-I.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic [1:0] last_owner,
  output logic [1:0] winner
);

`ifdef ARB_RR_EN
  // On contention favour whoever was not granted most recently.
  always_comb begin
    winner = OWN_NONE;
    if (req_i && req_d) winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    else if (req_d)     winner = OWN_D;
    else if (req_i)     winner = OWN_I;
  end
`else
  // Fixed priority ignores history; D always beats I.
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;

  always_comb begin
    winner = OWN_NONE;
    if (req_d)      winner = OWN_D;
    else if (req_i) winner = OWN_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache transactions onto one fixed-latency memory port.
// Optional build macro ARB_RR_EN selects round-robin arbitration (see arb_pick2).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  state_e            state_q;
  logic [1:0]        owner_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              i_done_q, d_done_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              mem_rd_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        last_owner;
  logic [1:0]        winner;

  arb_pick2 u_pick (
    .req_i      (bus.i_req),
    .req_d      (bus.d_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

`ifdef ARB_RR_EN
  logic [1:0] last_owner_q;
  // Remember the most recent grant; reset to I so D wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= OWN_I;
    else if (state_q == IDLE && winner != OWN_NONE) last_owner_q <= winner;
  end
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_I;
`endif

  // Transaction FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winner == OWN_D) begin
            owner_q     <= OWN_D;
            wr_q        <= bus.d_wr;
            mem_rd_q    <= ~bus.d_wr;
            mem_wr_q    <= bus.d_wr;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            state_q     <= ISSUE;
          end else if (winner == OWN_I) begin
            owner_q     <= OWN_I;
            wr_q        <= 1'b0;
            mem_rd_q    <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Command stays asserted until memory stops stalling.
          if (!bus.mem_stall) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            cnt_q    <= CNT_W'(MEM_LAT);
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (owner_q == OWN_I) begin
              i_rdata_q <= bus.mem_rdata;
              i_done_q  <= 1'b1;
            end else begin
              if (!wr_q) d_rdata_q <= bus.mem_rdata;
              d_done_q <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // Done pulse is visible this cycle; requests are ignored here.
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_done    = i_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=4).
// Expectations for the contention test follow the ARB_RR_EN build macro.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.MEM_LAT(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until a done pulse is seen (bounded); n = cycles advanced.
  task automatic wait_done(output int n, output logic who_i, output logic who_d);
    n = 0; who_i = 1'b0; who_d = 1'b0;
    while (n < 60) begin
      tick();
      n++;
      if (bus.i_done || bus.d_done) begin
        who_i = bus.i_done;
        who_d = bus.d_done;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   n;
    logic wi, wd;
    logic seen;
    logic exp_d;

    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_stall = 0;

    // Reset state
    tick();
    tick();
    chk("rst_busy",  bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_done",  {bus.i_done, bus.d_done}, 0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    chk("rst_cmd",   {bus.mem_rd, bus.mem_wr}, 0);
    chk("rst_bus",   {bus.mem_addr, bus.mem_wdata}, 0);
    rst = 1'b0;
    tick();

    // Unstalled I read
    bus.i_req = 1; bus.i_addr = 16'h0040; bus.mem_rdata = 16'hBEEF;
    tick();                                         // cycle 1: ISSUE
    chk("i_rd_c1",    {bus.mem_rd, bus.mem_wr}, 2'b10);
    chk("i_addr_c1",  bus.mem_addr, 16'h0040);
    chk("i_owner_c1", bus.owner, 1);
    chk("i_busy_c1",  bus.busy, 1);
    tick();                                         // cycle 2: WAIT
    chk("i_rd_c2",    bus.mem_rd, 0);
    wait_done(n, wi, wd);
    chk("i_lat",      n + 2, 6);
    chk("i_who",      {wi, wd}, 2'b10);
    chk("i_rdata",    bus.i_rdata, 16'hBEEF);
    chk("i_owner_dn", bus.owner, 1);
    bus.i_req = 0;
    tick();
    chk("i_done_off", bus.i_done, 0);
    chk("i_owner_end", bus.owner, 0);
    chk("i_busy_end", bus.busy, 0);

    // D write with 3 stall cycles
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h1000; bus.d_wdata = 16'h1234;
    bus.mem_stall = 1; bus.mem_rdata = 16'h5555;
    tick();                                         // cycle 1
    bus.d_addr = 16'hFFFF; bus.d_wdata = 16'h0000;   // changes after latch are ignored
    chk("dw_owner", bus.owner, 2);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus.mem_stall = 0;
      chk($sformatf("dw_wr_c%0d", c), {bus.mem_rd, bus.mem_wr}, 2'b01);
      chk($sformatf("dw_ad_c%0d", c), {bus.mem_addr, bus.mem_wdata}, {16'h1000, 16'h1234});
      tick();
    end
    chk("dw_wr_c5", bus.mem_wr, 0);                 // cycle 5: WAIT
    wait_done(n, wi, wd);
    chk("dw_lat",   n + 5, 9);
    chk("dw_who",   {wi, wd}, 2'b01);
    chk("dw_rdata", bus.d_rdata, 16'h0000);
    bus.d_req = 0; bus.d_wr = 0;
    tick();
    chk("dw_busy_end", bus.busy, 0);

    // Simultaneous requests from a fresh reset: D first, then I
    do_reset();
    bus.i_req = 1; bus.i_addr = 16'h0200;
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0300; bus.mem_rdata = 16'hD00D;
    tick();
    chk("sim_owner1", bus.owner, 2);
    chk("sim_addr1",  bus.mem_addr, 16'h0300);
    wait_done(n, wi, wd);
    chk("sim_d_lat",  n + 1, 6);
    chk("sim_d_who",  {wi, wd}, 2'b01);
    chk("sim_d_rdat", bus.d_rdata, 16'hD00D);
    bus.d_req = 0; bus.mem_rdata = 16'h1111;
    wait_done(n, wi, wd);
    chk("sim_gap",    n, 7);
    chk("sim_i_who",  {wi, wd}, 2'b10);
    chk("sim_i_rdat", bus.i_rdata, 16'h1111);
    bus.i_req = 0;
    tick();

    // Both requesters held for 4 transactions
    do_reset();
    bus.i_req = 1; bus.d_req = 1; bus.d_wr = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      wait_done(n, wi, wd);
      chk($sformatf("hold_lat%0d", k), n, (k == 0) ? 6 : 7);
      chk($sformatf("hold_who%0d", k), {wi, wd}, {~exp_d, exp_d});
    end
    bus.i_req = 0; bus.d_req = 0;
    tick();
    tick();

    // Reset during WAIT abandons the I read
    bus.i_req = 1; bus.i_addr = 16'h0040; bus.mem_rdata = 16'h7777;
    tick();
    tick();
    tick();                                         // cycle 3: WAIT
    rst = 1; bus.i_req = 0;
    tick();
    rst = 0;
    chk("rw_busy",  bus.busy, 0);
    chk("rw_owner", bus.owner, 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.i_done) seen = 1;
      tick();
    end
    chk("rw_no_done", seen, 0);
    chk("rw_rdata",   bus.i_rdata, 16'h0000);
    bus.i_req = 1; bus.i_addr = 16'h0080; bus.mem_rdata = 16'h4242;
    tick();
    chk("rw_addr2", bus.mem_addr, 16'h0080);
    wait_done(n, wi, wd);
    chk("rw_lat2",   n + 1, 6);
    chk("rw_rdata2", bus.i_rdata, 16'h4242);
    bus.i_req = 0;
    tick();

    // Owner drops request during WAIT
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0500; bus.mem_rdata = 16'hCAFE;
    tick();
    tick();                                         // cycle 2: WAIT
    bus.d_req = 0;
    wait_done(n, wi, wd);
    chk("drop_lat",   n + 2, 6);
    chk("drop_who",   {wi, wd}, 2'b01);
    chk("drop_rdata", bus.d_rdata, 16'hCAFE);
    tick();
    chk("drop_busy1", bus.busy, 0);
    tick();
    chk("drop_busy2", {bus.busy, bus.owner}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port (four-bank, fixed latency) between the instruction-cache fill path and the data-cache fill/writeback path.
- Sits between the two cache controllers and main memory inside proc_hier.
- Serialises one memory transaction at a time and returns read data plus a one-cycle done pulse to the owning requester.
- Exposes owner/busy status so the bench can count I/D memory traffic alongside the cache hit/request counters.

Parameters:
- MEM_LAT, 4: cycles from memory accepting a command to read data being valid.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache requests a memory read; held until i_done
- i_addr  in  ADDR_W  I-cache read address; stable while i_req
- i_done  out  1  one-cycle pulse, I transaction complete
- i_rdata  out  DATA_W  read data, valid when i_done
- d_req  in  1  D-cache requests a memory access; held until d_done
- d_wr  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  D-cache address
- d_wdata  in  DATA_W  D-cache write data
- d_done  out  1  one-cycle pulse, D transaction complete
- d_rdata  out  DATA_W  read data, valid when d_done and not d_wr
- mem_rd  out  1  memory read command
- mem_wr  out  1  memory write command
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_stall  in  1  memory cannot accept the command this cycle (bank busy)
- busy  out  1  arbiter not in IDLE
- owner  out  2  0 = none, 1 = I, 2 = D

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State goes to IDLE; owner=0, busy=0.
  - i_done=d_done=0; i_rdata=d_rdata=0.
  - mem_rd=mem_wr=0; mem_addr and mem_wdata are 0.
  - Reset mid-transaction abandons the transaction; no done pulse is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - Otherwise pick a winner, latch the winner's owner, command, address and write data, and go to ISSUE.
  - Fixed priority: D beats I when both requests are high in the same cycle.
- ISSUE:
  - Drive mem_rd/mem_wr, mem_addr and mem_wdata from the latched values.
  - If mem_stall=1, stay in ISSUE and keep the command asserted.
  - If mem_stall=0, the command is accepted: load the latency counter with MEM_LAT and go to WAIT.
- WAIT:
  - Memory commands are deasserted; the counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
  - For writes the capture is suppressed and d_rdata holds its previous value.
- DONE:
  - Pulse the owner's done for exactly one cycle, then go to IDLE.
  - Requests are not sampled in DONE.
- Latency:
  - Unstalled request sampled in IDLE at cycle 0 → ISSUE in cycle 1, WAIT in cycles 2..MEM_LAT+1, done in cycle MEM_LAT+2.
  - Each stall cycle adds one cycle.
- Requester rules:
  - A requester must deassert req in the cycle after done, or it is re-granted.
  - If req drops while owned, the transaction still completes and done still pulses.
  - Address, data and command changes by the owner after latching are ignored.
  - A non-owner's request waits and is evaluated at the next IDLE.
- Counter width is clog2(MEM_LAT+1); MEM_LAT=1 gives a single WAIT cycle.
- i_done and d_done are never high in the same cycle.
- busy=1 in ISSUE, WAIT and DONE.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. A last_owner flop (reset value: I, so D wins first) gives priority to the requester that was not granted most recently; the flop updates on each grant.
- Undefined: fixed D-over-I priority and no last_owner flop.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - owner encoding constants OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2
- Sub-module arb_pick2:
  - Combinational two-requester picker with inputs req_i, req_d and last_owner.
  - Output is the winner code.
  - Contains the ARB_RR_EN switch, so the top FSM is identical in both builds.

Test Plan:
- Unstalled I read: i_req=1, i_addr=0x0040, MEM_LAT=4, mem_rdata=0xBEEF in the capture cycle → mem_rd=1 with mem_addr=0x0040 for one cycle; i_done pulses 6 cycles after request sampling; i_rdata=0xBEEF; owner=1 then 0.
- D write with stall: d_req=1, d_wr=1, d_addr=0x1000, d_wdata=0x1234, mem_stall=1 for 3 cycles → mem_wr held 4 cycles with a stable address and data; d_done pulses 9 cycles after sampling; d_rdata unchanged.
- Simultaneous requests, fixed priority: both req high in IDLE → D served first, then I; i_done follows d_done by MEM_LAT+3=7 cycles (IDLE re-entry is included).
- ARB_RR_EN build, both requesters held continuously for 4 transactions → grants alternate D, I, D, I.
- Reset in WAIT: rst=1 for one cycle with an I read in flight → next cycle IDLE, busy=0, no i_done pulse; a subsequent request completes normally.
- Owner drops req in WAIT: d_req falls mid-read → d_done still pulses; the arbiter returns to IDLE and does not re-grant D.
